// File: rtl/aes_key_expand_if.sv
// Round-key stream bundle between the key-schedule engine and its controller/consumer.
// The slave modport is the engine side; the master modport drives start/key and accepts keys.
interface aes_key_expand_if;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] round_key;
    logic [3:0]   rk_round;
    logic         done;

    modport slave (
        input  start, key, rk_ready,
        output busy, rk_valid, round_key, rk_round, done
    );

    modport master (
        output start, key, rk_ready,
        input  busy, rk_valid, round_key, rk_round, done
    );
endinterface

// File: rtl/aes_key_expand.sv
// Iterative AES-128 key schedule: emits round keys 0..10 one per valid/ready handshake.
// Includes the byte S-box used for SubWord (GF(2^8) inverse followed by the affine map).
module sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] z);
        logic [7:0] p;
        logic [7:0] b;
        p = 8'h00;
        b = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ b;
            b = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0): product of x^(2^k) for k=1..7.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic [7:0] inv;

    // NOTE: every signal written in always_comb gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        inv = gf_inv(a);
        y   = inv
            ^ {inv[6:0], inv[7]}
            ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]}
            ^ 8'h63;
    end
endmodule

module aes_key_expand (
    input  logic               clk,
    input  logic               rst,
    aes_key_expand_if.slave    kx
);
    typedef enum logic {IDLE, EMIT} state_t;

    state_t       state;
    logic         busy_q;
    logic         rk_valid_q;
    logic         done_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;

    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;
    logic [31:0]  temp;
    logic [31:0]  n0, n1, n2, n3;
    logic [3:0]   next_round;
    logic         handshake;

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign {w0, w1, w2, w3} = rk_q;
    assign rot_w3     = {w3[23:0], w3[31:24]};
    assign next_round = round_q + 4'd1;

    for (genvar g = 0; g < 4; g++) begin : g_subword
        sbox u_sbox (
            .a (rot_w3[8*g +: 8]),
            .y (sub_w3[8*g +: 8])
        );
    end

    assign temp = sub_w3 ^ {rcon(next_round), 24'h0};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;

    assign handshake = rk_valid_q & kx.rk_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rk_q       <= 128'h0;
            round_q    <= 4'd0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (kx.start) begin
                        rk_q       <= kx.key;
                        round_q    <= 4'd0;
                        busy_q     <= 1'b1;
                        rk_valid_q <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (handshake) begin
                        if (round_q == 4'd10) begin
                            busy_q     <= 1'b0;
                            rk_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rk_q    <= {n0, n1, n2, n3};
                            round_q <= next_round;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign kx.busy      = busy_q;
    assign kx.rk_valid  = rk_valid_q;
    assign kx.done      = done_q;
    assign kx.round_key = rk_q;
    assign kx.rk_round  = round_q;
endmodule

// File: tb/tb_aes_key_expand.sv
// Self-checking bench for aes_key_expand: FIPS-197 vectors, random keys with random backpressure,
// start/key noise while busy, mid-schedule reset and back-to-back schedules.
module tb_aes_key_expand;
    logic clk;
    logic rst;

    aes_key_expand_if kx ();

    aes_key_expand dut (
        .clk (clk),
        .rst (rst),
        .kx  (kx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [0:255][7:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_RK2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
    localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    int vectors;
    int miscompares;

    logic [127:0] exp_rk [0:10];
    logic [127:0] got_rk [0:10];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {SBOX_TAB[t[31:24]], SBOX_TAB[t[23:16]], SBOX_TAB[t[15:8]], SBOX_TAB[t[7:0]]};
    endfunction

    // Textbook word-array expansion (w[0..43]) with rcon generated by repeated doubling in GF(2^8).
    task automatic model_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered just after an edge with the DUT idle; returns just after the edge that produces done.
    task automatic run_schedule(input logic [127:0] k, input bit rand_ready, input bit noise);
        int  idx;
        int  cyc;
        bit  finished;
        bit  ready;
        model_expand(k);
        kx.start = 1'b1;
        kx.key   = k;
        kx.rk_ready = 1'b0;
        @(posedge clk); #1;
        cyc = 1;
        kx.start = 1'b0;
        check("start_busy",  128'(kx.busy), 128'd1);
        check("start_done",  128'(kx.done), 128'd0);
        idx = 0;
        finished = 1'b0;
        for (int c = 0; c < 300 && !finished; c++) begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            kx.rk_ready = ready;
            if (noise) begin
                kx.start = 1'($urandom_range(0, 1));
                kx.key   = rand128();
                if (idx == 10 && ready) kx.start = 1'b1;
            end
            check("busy",      128'(kx.busy),     128'd1);
            check("rk_valid",  128'(kx.rk_valid), 128'd1);
            check("done_low",  128'(kx.done),     128'd0);
            check("rk_round",  128'(kx.rk_round), 128'(idx));
            check("round_key", kx.round_key,      exp_rk[idx]);
            if (ready) got_rk[idx] = kx.round_key;
            @(posedge clk); #1;
            cyc++;
            if (ready) begin
                idx++;
                if (idx == 11) finished = 1'b1;
            end
        end
        kx.start    = 1'b0;
        kx.rk_ready = 1'b0;
        if (!finished) check("timeout", 128'd0, 128'd1);
        check("done_pulse", 128'(kx.done),     128'd1);
        check("end_busy",   128'(kx.busy),     128'd0);
        check("end_valid",  128'(kx.rk_valid), 128'd0);
        if (!rand_ready) check("latency", 128'(cyc), 128'd12);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        check("idle_done", 128'(kx.done), 128'd0);
        check("idle_busy", 128'(kx.busy), 128'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        kx.start    = 1'b0;
        kx.key      = 128'h0;
        kx.rk_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  128'(kx.busy),     128'd0);
        check("rst_valid", 128'(kx.rk_valid), 128'd0);
        check("rst_done",  128'(kx.done),     128'd0);
        check("rst_rk",    kx.round_key,      128'h0);
        check("rst_round", 128'(kx.rk_round), 128'd0);
        rst = 1'b0;
        idle_cycle();

        run_schedule(FIPS_KEY, 1'b0, 1'b0);
        check("fips_rk0",  got_rk[0],  FIPS_KEY);
        check("fips_rk1",  got_rk[1],  FIPS_RK1);
        check("fips_rk2",  got_rk[2],  FIPS_RK2);
        check("fips_rk10", got_rk[10], FIPS_RK10);
        idle_cycle();

        run_schedule(128'h0, 1'b0, 1'b0);
        check("zero_rk1",  got_rk[1],  ZERO_RK1);
        check("zero_rk10", got_rk[10], ZERO_RK10);
        idle_cycle();

        // Backpressure with start/key noise; start forced high in the final handshake cycle.
        for (int n = 0; n < 4; n++) begin
            run_schedule(rand128(), 1'b1, 1'b1);
            idle_cycle();
        end
        run_schedule(FIPS_KEY, 1'b1, 1'b0);
        check("bp_fips_rk10", got_rk[10], FIPS_RK10);

        // Back-to-back: each new start is driven in the done cycle.
        run_schedule(FIPS_KEY, 1'b0, 1'b0);
        run_schedule(rand128(), 1'b0, 1'b0);
        run_schedule(128'h0, 1'b0, 1'b1);
        idle_cycle();

        // Reset while round 5 is presented.
        kx.start = 1'b1;
        kx.key   = rand128();
        @(posedge clk); #1;
        kx.start    = 1'b0;
        kx.rk_ready = 1'b1;
        for (int c = 0; c < 20 && kx.rk_round != 4'd5; c++) begin
            @(posedge clk); #1;
        end
        check("reached_r5", 128'(kx.rk_round), 128'd5);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        kx.rk_ready = 1'b0;
        check("mid_rst_busy",  128'(kx.busy),     128'd0);
        check("mid_rst_valid", 128'(kx.rk_valid), 128'd0);
        check("mid_rst_done",  128'(kx.done),     128'd0);
        check("mid_rst_rk",    kx.round_key,      128'h0);
        check("mid_rst_round", 128'(kx.rk_round), 128'd0);
        idle_cycle();
        run_schedule(FIPS_KEY, 1'b0, 1'b0);
        check("post_rst_rk10", got_rk[10], FIPS_RK10);
        idle_cycle();

        for (int n = 0; n < 3; n++) begin
            run_schedule(rand128(), 1'b0, 1'b1);
            idle_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aes_key_expand.md
# aes_key_expand

Iterative AES-128 key-schedule engine that produces the 11 round keys (round 0..10) one per handshake from a 128-bit cipher key. It sits directly downstream of `sbox`: it instantiates four `sbox` copies for SubWord and consumes their outputs every cycle. The AddRoundKey/round datapath consumes its round keys through a valid/ready stream.

## Interface
- Parameters: none. AES-128 only; key width and round count are fixed at 128 bits and 10 rounds.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: request expansion of `key`; sampled only in IDLE.
- `key` input 128: cipher key, captured on accepted `start`. Byte 0 is `key[127:120]`.
- `busy` output 1: high while not IDLE.
- `rk_valid` output 1: `round_key`/`rk_round` valid.
- `rk_ready` input 1: consumer accepts current round key.
- `round_key` output 128: current round key, words w0..w3 = [127:96]..[31:0].
- `rk_round` output 4: index of `round_key`, 0..10.
- `done` output 1: one-cycle pulse after round 10 is accepted.

## Operation
- FSM states: IDLE, EMIT.
- IDLE:
  - `busy`=0, `rk_valid`=0.
  - On `start`=1: `round_key`<=`key`, `rk_round`<=0, go to EMIT.
- EMIT:
  - `busy`=1, `rk_valid`=1.
  - Handshake = `rk_valid & rk_ready`.
  - Without handshake, hold `round_key` and `rk_round` stable; no recomputation.
  - On handshake with `rk_round`<10: `round_key`<=next(`round_key`, rcon[`rk_round`+1]), `rk_round`+=1, stay in EMIT.
  - On handshake with `rk_round`==10: go to IDLE, pulse `done` next cycle.
- next(w0..w3, rc):
  - temp = SubWord(RotWord(w3)) ^ {rc, 24'h0}.
  - RotWord(a0,a1,a2,a3) = (a1,a2,a3,a0).
  - SubWord applies `sbox` bytewise.
  - n0 = w0^temp; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36. Constant table indexed by 4-bit round; indices 0, 11-15 unused (return 00).
- SubWord is combinational within the cycle: four `sbox` instances on rotated w3, no extra pipeline stage.
- `key` is not retained after capture; changes to `key` while busy have no effect.
- `start` while busy is ignored, including in the cycle of the final handshake. A new start is accepted no earlier than the cycle `busy` reads 0.
- `done` is registered and high exactly one cycle: the first IDLE cycle after the final handshake.

## Timing
- Reset values: `busy`=0, `rk_valid`=0, `done`=0, `round_key`=128'h0, `rk_round`=0, state IDLE.
- Reset has priority over every other input. Reset mid-EMIT abandons the schedule; the next cycle is IDLE with reset values and no `done`.
- `start` accepted at edge N: `rk_valid`=1 with round 0 after edge N.
- With `rk_ready` held high: rounds 0..10 on 11 consecutive cycles; `done`=1 and `busy`=0 on the 12th cycle after the start edge.
- Start-to-start minimum: 12 cycles.
- Each stall cycle (`rk_ready`=0) extends the schedule by one cycle with outputs frozen.
- `rk_round` never exceeds 10; no wrap.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, `rk_ready`=1:
  - rk0 = key; rk1 = a0fafe1788542cb123a339392a6c7605; rk2 = f2c295f27a96b9435935807a7359f67f; rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `done` on cycle 12.
- All-zero key: rk1 = 62636363626363636263636362636363; rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure:
  - Random `rk_ready` (~50%): round-key sequence identical to the stall-free run.
  - Outputs stable during stalls; exactly 11 handshakes, one `done`.
- `start` pulses and `key` changes while busy: no effect on sequence; `start` in the final-handshake cycle ignored; `start` on the following cycle accepted.
- Assert `rst` while `rk_round`=5: next cycle all outputs at reset values, no `done`. A fresh `start` then yields the correct rk0..rk10.
- Back-to-back: second key started the cycle `busy` drops; both schedules correct, two `done` pulses 12 cycles apart.
